// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI transfer arbiter.
package spi_pkg;

  localparam int DATA_WIDTH = 8;

  // Bit positions inside a requester's 2-bit direction field.
  localparam int DIR_RX = 0;
  localparam int DIR_TX = 1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    BUSY,
    RESP,
    GUARD
  } arb_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module spi_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin : pick
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr_i) + i) % NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI engine between NUM_REQ requesters, with guard time and timeout.
// Optional statistics counters (frame_cnt, err_cnt) are built when SPI_ARB_STATS_EN is defined.
module spi_xfer_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GUARD_CYCLES   = 60,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                                clk,
  input  logic                                reset_bar,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][1:0]             req_dir,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic                                rsp_err,
  output logic                                eng_rx_start,
  output logic                                eng_tx_start,
  output logic [DATA_WIDTH-1:0]               eng_tx_data,
  input  logic [DATA_WIDTH-1:0]               eng_rx_data,
  input  logic                                eng_rx_valid,
  input  logic                                eng_tx_done,
  output logic                                busy,
  output arb_state_t                          dbg_state
`ifdef SPI_ARB_STATS_EN
  ,
  output logic [15:0]                         frame_cnt,
  output logic [7:0]                          err_cnt
`endif
);

  // Handshake: a requester holds req_valid (with dir/wdata) until it sees its rsp_valid;
  // req_ready pulses once when dir/wdata are captured, rsp_valid pulses once with rsp_rdata/rsp_err.
  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        widx_q, widx_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [1:0]              dir_q, dir_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    armed_q, armed_d;
  logic                    flag_q;

  logic [NUM_REQ-1:0]      pick_grant;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic                    done_edge;

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Flags left high by the previous frame must first be seen low before a rise counts.
  assign done_edge   = armed_q && flag_q;
  assign eng_tx_data = wdata_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    widx_d       = widx_q;
    grant_d      = grant_q;
    dir_d        = dir_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    armed_d      = armed_q;
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_rdata    = '0;
    rsp_err      = 1'b0;
    eng_rx_start = 1'b0;
    eng_tx_start = 1'b0;
    busy         = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = LAUNCH;
          grant_d = pick_grant;
          widx_d  = pick_idx;
          dir_d   = req_dir[pick_idx];
          wdata_d = req_wdata[pick_idx];
        end
      end
      LAUNCH: begin
        req_ready    = grant_q;
        eng_rx_start = dir_q[DIR_RX];
        eng_tx_start = dir_q[DIR_TX];
        ptr_d        = (widx_q == IDX_W'(NUM_REQ - 1)) ? '0 : widx_q + IDX_W'(1);
        cnt_d        = '0;
        armed_d      = 1'b0;
        rdata_d      = '0;
        if (dir_q == 2'b00) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          err_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!flag_q) armed_d = 1'b1;
        if (done_edge) begin
          rdata_d = eng_rx_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = grant_q;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        cnt_d     = '0;
        state_d   = (dir_q != 2'b00) ? GUARD : IDLE;
      end
      GUARD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      widx_q  <= '0;
      grant_q <= '0;
      dir_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      widx_q  <= widx_d;
      grant_q <= grant_d;
      dir_q   <= dir_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      flag_q  <= eng_rx_valid | eng_tx_done;
    end
  end

`ifdef SPI_ARB_STATS_EN
  // Saturating: frame_cnt counts error-free completions, err_cnt counts rsp_err responses.
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (state_q == RESP) begin
      if (err_q) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 8'd1;
      end else begin
        if (frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with a behavioural loopback SPI engine model.
module tb_spi_xfer_arbiter;
  import spi_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DW      = DATA_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         reset_bar;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0][1:0]      req_dir;
  logic [NUM_REQ-1:0][DW-1:0]   req_wdata;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [DW-1:0]                rsp_rdata;
  logic                         rsp_err;
  logic                         eng_rx_start;
  logic                         eng_tx_start;
  logic [DW-1:0]                eng_tx_data;
  logic [DW-1:0]                eng_rx_data  = '0;
  logic                         eng_rx_valid = 1'b0;
  logic                         eng_tx_done  = 1'b0;
  logic                         busy;
  arb_state_t                   dbg_state;

  spi_xfer_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .GUARD_CYCLES   (60),
    .TIMEOUT_CYCLES (1023)
  ) dut (
    .clk          (clk),
    .reset_bar    (reset_bar),
    .req_valid    (req_valid),
    .req_dir      (req_dir),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .eng_rx_start (eng_rx_start),
    .eng_tx_start (eng_tx_start),
    .eng_tx_data  (eng_tx_data),
    .eng_rx_data  (eng_rx_data),
    .eng_rx_valid (eng_rx_valid),
    .eng_tx_done  (eng_tx_done),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_d_q[$];
  logic [7:0] grant_seen_q[$];
  logic [7:0] rsp_idx_q[$];
  logic [7:0] rsp_data_q[$];
  time        launch_t_q[$];

  // ---------------- engine model ----------------
  // Start seen -> flags drop after eng_clr_at cycles, rise after eng_done_at cycles (unless hung).
  bit         eng_run     = 1'b0;
  bit         eng_hang    = 1'b0;
  int         eng_cnt     = 0;
  int         eng_clr_at  = 1;
  int         eng_done_at = 6;
  bit         m_rx        = 1'b0;
  bit         m_tx        = 1'b0;
  logic [7:0] m_data      = '0;
  int         rx_starts   = 0;
  int         tx_starts   = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (eng_run) begin
        eng_cnt++;
        if (eng_cnt == eng_clr_at) begin
          eng_rx_valid = 1'b0;
          eng_tx_done  = 1'b0;
        end
        if (eng_cnt == eng_done_at) begin
          if (!eng_hang) begin
            eng_rx_valid = m_rx;
            eng_tx_done  = m_tx;
            eng_rx_data  = m_data;
          end
          eng_run = 1'b0;
        end
      end
      if (eng_rx_start || eng_tx_start) begin
        eng_run = 1'b1;
        eng_cnt = 0;
        m_rx    = eng_rx_start;
        m_tx    = eng_tx_start;
        m_data  = eng_tx_data;
        if (eng_rx_start) rx_starts++;
        if (eng_tx_start) tx_starts++;
      end
    end
  end

  function automatic logic [7:0] onehot2idx(input logic [NUM_REQ-1:0] v);
    logic [7:0] r;
    r = 8'hFF;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (v[i]) r = 8'(i);
    return r;
  endfunction

  // Records every grant and response with its time.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (req_ready != '0) begin
        grant_seen_q.push_back(onehot2idx(req_ready));
        launch_t_q.push_back($time);
      end
      if (rsp_valid != '0) begin
        rsp_idx_q.push_back(onehot2idx(rsp_valid));
        rsp_data_q.push_back(rsp_rdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag, input int max_c, output int n);
    n = 0;
    while (rsp_valid == '0 && n < max_c) begin
      tick();
      n++;
    end
    chk(tag, 32'(rsp_valid != '0), 32'd1);
  endtask

  task automatic wait_grant(input string tag, input int max_c, output int n);
    n = 0;
    while (req_ready == '0 && n < max_c) begin
      tick();
      n++;
    end
    chk(tag, 32'(req_ready != '0), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int max_c, output int n);
    n = 0;
    while (busy && n < max_c) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(busy),         32'd0);
    chk({tag, "_ready"},  32'(req_ready),    32'd0);
    chk({tag, "_rspv"},   32'(rsp_valid),    32'd0);
    chk({tag, "_rxst"},   32'(eng_rx_start), 32'd0);
    chk({tag, "_txst"},   32'(eng_tx_start), 32'd0);
    chk({tag, "_txdata"}, 32'(eng_tx_data),  32'd0);
    chk({tag, "_rdata"},  32'(rsp_rdata),    32'd0);
    chk({tag, "_err"},    32'(rsp_err),      32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int rx0;
    int tx0;
    reset_bar = 1'b0;
    req_valid = '0;
    req_dir   = '0;
    req_wdata = '0;
    repeat (3) tick();
    chk_all_zero("rst");
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    reset_bar = 1'b1;
    tick();
    chk("rst_idle", 32'(busy), 32'd0);

    // Single request, loopback A5: launch at N+1, response 2 cycles after flag rise (launch+8).
    req_dir[0]   = 2'b11;
    req_wdata[0] = 8'hA5;
    req_valid    = 4'b0001;
    tick();
    chk("t1_ready",   32'(req_ready),    32'h1);
    chk("t1_rxstart", 32'(eng_rx_start), 32'd1);
    chk("t1_txstart", 32'(eng_tx_start), 32'd1);
    chk("t1_txdata",  32'(eng_tx_data),  32'hA5);
    wait_rsp("t1_rsp_seen", 40, n);
    chk("t1_latency", 32'(n),         32'd8);
    chk("t1_rspv",    32'(rsp_valid), 32'h1);
    chk("t1_rdata",   32'(rsp_rdata), 32'hA5);
    chk("t1_err",     32'(rsp_err),   32'd0);
    req_valid = '0;
    chk("t1_rx_starts", 32'(rx_starts), 32'd1);
    chk("t1_tx_starts", 32'(tx_starts), 32'd1);
    wait_idle("t1_idle", 100, n);
    chk("t1_guard_len", 32'(n), 32'd61);

    // Reset during BUSY: outputs clear at once, no response, pointer back to 0.
    req_dir[1]   = 2'b11;
    req_wdata[1] = 8'h96;
    req_valid    = 4'b0010;
    tick();
    chk("t6_ready", 32'(req_ready), 32'h2);
    repeat (3) tick();
    chk("t6_busy", 32'(busy), 32'd1);
    rsp_idx_q.delete();
    reset_bar = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    req_valid = '0;
    repeat (2) tick();
    reset_bar = 1'b1;
    repeat (10) tick();
    chk("t6_no_rsp", 32'(rsp_idx_q.size()), 32'd0);
    chk("t6_idle",   32'(busy),             32'd0);
    req_dir[3]   = 2'b11;
    req_wdata[3] = 8'h5C;
    req_valid    = 4'b1010;
    tick();
    chk("t6_ptr0_grant", 32'(req_ready), 32'h2);
    req_valid = '0;
    wait_rsp("t6_rsp_seen", 40, n);
    chk("t6_latency", 32'(n),         32'd8);
    chk("t6_rspv",    32'(rsp_valid), 32'h2);
    chk("t6_rdata",   32'(rsp_rdata), 32'h96);
    wait_idle("t6_idle2", 100, n);

    // All four held after reset: order 0,1,2,3,0; launch-to-launch = 8 + 1 + 60 + 1 = 70 cycles.
    reset_bar = 1'b0;
    repeat (2) tick();
    reset_bar = 1'b1;
    tick();
    grant_seen_q.delete();
    launch_t_q.delete();
    rsp_idx_q.delete();
    rsp_data_q.delete();
    req_dir   = {2'b11, 2'b11, 2'b11, 2'b11};
    req_wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    n = 0;
    while (grant_seen_q.size() < 5 && n < 500) begin
      tick();
      n++;
    end
    req_valid = '0;
    wait_idle("t2_idle", 200, n);
    exp_q   = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    exp_d_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    chk("t2_grant_cnt", 32'(grant_seen_q.size()), 32'd5);
    chk("t2_rsp_cnt",   32'(rsp_idx_q.size()),    32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_seen_q.size()) chk($sformatf("t2_grant%0d", i), 32'(grant_seen_q[i]), 32'(exp_q[i]));
      if (i < rsp_idx_q.size()) begin
        chk($sformatf("t2_rsp_idx%0d", i),  32'(rsp_idx_q[i]),  32'(exp_q[i]));
        chk($sformatf("t2_rsp_data%0d", i), 32'(rsp_data_q[i]), 32'(exp_d_q[i]));
      end
      if (i < 4 && i + 1 < launch_t_q.size())
        chk($sformatf("t2_gap%0d", i), 32'((launch_t_q[i+1] - launch_t_q[i]) / 10), 32'd70);
    end

    // Illegal direction on requester 2 (pointer is 1): no start, error response next cycle, then IDLE.
    rx0          = rx_starts;
    tx0          = tx_starts;
    req_dir[2]   = 2'b00;
    req_valid    = 4'b0100;
    tick();
    chk("t4_ready",   32'(req_ready),    32'h4);
    chk("t4_rxstart", 32'(eng_rx_start), 32'd0);
    chk("t4_txstart", 32'(eng_tx_start), 32'd0);
    req_valid = '0;
    tick();
    chk("t4_rspv",  32'(rsp_valid), 32'h4);
    chk("t4_err",   32'(rsp_err),   32'd1);
    chk("t4_rdata", 32'(rsp_rdata), 32'd0);
    tick();
    chk("t4_idle",      32'(busy),      32'd0);
    chk("t4_no_rx_st",  32'(rx_starts), 32'(rx0));
    chk("t4_no_tx_st",  32'(tx_starts), 32'(tx0));

    // Stale flags held 5 cycles into the frame: fall at +5, rise at +10, response at +12.
    eng_clr_at   = 5;
    eng_done_at  = 10;
    req_dir[3]   = 2'b01;
    req_wdata[3] = 8'h3C;
    req_valid    = 4'b1000;
    tick();
    chk("t5_ready",   32'(req_ready),    32'h8);
    chk("t5_rxstart", 32'(eng_rx_start), 32'd1);
    chk("t5_txstart", 32'(eng_tx_start), 32'd0);
    req_valid = '0;
    wait_rsp("t5_rsp_seen", 40, n);
    chk("t5_latency", 32'(n),         32'd12);
    chk("t5_rspv",    32'(rsp_valid), 32'h8);
    chk("t5_rdata",   32'(rsp_rdata), 32'h3C);
    chk("t5_err",     32'(rsp_err),   32'd0);
    wait_idle("t5_idle", 100, n);
    eng_clr_at  = 1;
    eng_done_at = 6;

    // Engine hangs: timeout 1023 cycles after BUSY entry, guard, then requester 1 launches at +62.
    eng_hang     = 1'b1;
    req_dir[0]   = 2'b11;
    req_wdata[0] = 8'h5A;
    req_dir[1]   = 2'b11;
    req_wdata[1] = 8'h77;
    req_valid    = 4'b0011;
    tick();
    chk("t3_ready", 32'(req_ready), 32'h1);
    req_valid = 4'b0010;
    wait_rsp("t3_rsp_seen", 1100, n);
    chk("t3_timeout_lat", 32'(n),         32'd1024);
    chk("t3_rspv",        32'(rsp_valid), 32'h1);
    chk("t3_err",         32'(rsp_err),   32'd1);
    chk("t3_rdata",       32'(rsp_rdata), 32'd0);
    eng_hang = 1'b0;
    wait_grant("t3_next_seen", 100, n);
    chk("t3_next_lat",   32'(n),         32'd62);
    chk("t3_next_grant", 32'(req_ready), 32'h2);
    req_valid = '0;
    wait_rsp("t3_rsp2_seen", 40, n);
    chk("t3_rsp2_lat",   32'(n),         32'd8);
    chk("t3_rsp2_rdata", 32'(rsp_rdata), 32'h77);
    chk("t3_rsp2_err",   32'(rsp_err),   32'd0);
    wait_idle("t3_idle", 100, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
